h14tx_reset_sequencer: RTL and testbench

//   Ordered reset release for the HDMI 1.4 TX chain. Holds NUM_STAGES downstream reset

---
 rtl/h14tx_reset_sequencer.sv | 224 ++++++++++++++++++++++
 tb/tb_h14tx_reset_sequencer.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/h14tx_reset_sequencer.sv
// h14tx_reset_sequencer
//   Ordered reset release for the HDMI 1.4 TX chain, pixel clock domain.
//   Holds NUM_STAGES reset domains until the PLL lock is stable, then releases them
//   one at a time, STAGE_DELAY cycles apart (0 = serializer, 1 = TMDS encoders,
//   2 = video/packet scheduler). Lock loss or soft_rst_req re-asserts every stage.
//   Optional lock-wait timeout with PLL reset pulse: define H14TX_RSTSEQ_TIMEOUT_EN.
// Ports
//   clk          pixel clock
//   rst          asynchronous, active-high reset
//   pll_lock     PLL lock (asynchronous, synchronized internally)
//   soft_rst_req 1-cycle pulse, restarts the sequence
//   stage_rst    per-domain reset, active-high, registered
//   ready        all stages released
//   busy         sequence in progress
//   lock_timeout sticky lock-wait timeout flag (0 without the macro)
//   pll_rst      1-cycle PLL reset pulse on timeout (0 without the macro)
module h14tx_reset_sequencer #(
    parameter int unsigned NUM_STAGES     = 3,
    parameter int unsigned STAGE_DELAY    = 16,
    parameter int unsigned LOCK_FILTER    = 64,
    parameter int unsigned TIMEOUT_CYCLES = 4096
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  pll_lock,
    input  logic                  soft_rst_req,
    output logic [NUM_STAGES-1:0] stage_rst,
    output logic                  ready,
    output logic                  busy,
    output logic                  lock_timeout,
    output logic                  pll_rst
);

    localparam int unsigned MAX_AB = (LOCK_FILTER > STAGE_DELAY) ? LOCK_FILTER : STAGE_DELAY;
    localparam int unsigned MAX_C  = (MAX_AB > TIMEOUT_CYCLES) ? MAX_AB : TIMEOUT_CYCLES;
    localparam int unsigned CNT_W  = $clog2(MAX_C) + 1;
    localparam int unsigned IDX_W  = (NUM_STAGES > 1) ? $clog2(NUM_STAGES) : 1;

    localparam logic [CNT_W-1:0] FILT_LAST = CNT_W'(LOCK_FILTER - 1);
    localparam logic [CNT_W-1:0] DLY_LAST  = CNT_W'(STAGE_DELAY - 1);
    localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(NUM_STAGES - 1);

    typedef enum logic [2:0] {
        ST_ASSERT,
        ST_WAIT_LOCK,
        ST_FILTER,
        ST_RELEASE,
        ST_RUN
    } state_t;

    state_t                state_q, state_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic [IDX_W-1:0]      idx_q, idx_d;
    logic [NUM_STAGES-1:0] stage_rst_q, stage_rst_d;
    logic                  ready_q, ready_d;
    logic                  busy_q, busy_d;
    logic                  lock_meta_q, lock_s_q;

    // Two-flop synchronizer for the asynchronous PLL lock
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lock_meta_q <= 1'b0;
            lock_s_q    <= 1'b0;
        end else begin
            lock_meta_q <= pll_lock;
            lock_s_q    <= lock_meta_q;
        end
    end

`ifdef H14TX_RSTSEQ_TIMEOUT_EN
    localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    logic [CNT_W-1:0] wait_q, wait_d;
    logic             lock_timeout_q, lock_timeout_d;
    logic             pll_rst_q, pll_rst_d;
    logic             timeout_hit_c;

    // Lock-wait budget: accumulates across WaitLock/Filter, cleared only by Assert
    always_comb begin
        wait_d        = wait_q;
        timeout_hit_c = 1'b0;
        if (state_q == ST_ASSERT) begin
            wait_d = '0;
        end else if (state_q == ST_WAIT_LOCK || state_q == ST_FILTER) begin
            if (wait_q == TO_LAST) begin
                timeout_hit_c = 1'b1;
            end else begin
                wait_d = wait_q + CNT_W'(1);
            end
        end
        pll_rst_d = timeout_hit_c;
        if (soft_rst_req) begin
            lock_timeout_d = 1'b0;
        end else if (timeout_hit_c) begin
            lock_timeout_d = 1'b1;
        end else begin
            lock_timeout_d = lock_timeout_q;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wait_q         <= '0;
            lock_timeout_q <= 1'b0;
            pll_rst_q      <= 1'b0;
        end else begin
            wait_q         <= wait_d;
            lock_timeout_q <= lock_timeout_d;
            pll_rst_q      <= pll_rst_d;
        end
    end

    assign lock_timeout = lock_timeout_q;
    assign pll_rst      = pll_rst_q;
`else
    assign lock_timeout = 1'b0;
    assign pll_rst      = 1'b0;
`endif

    // Next-state and registered-output logic
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        idx_d       = idx_q;
        stage_rst_d = stage_rst_q;

        case (state_q)
            ST_ASSERT: begin
                state_d     = ST_WAIT_LOCK;
                cnt_d       = '0;
                idx_d       = '0;
                stage_rst_d = '1;
            end
            ST_WAIT_LOCK: begin
                cnt_d = '0;
                if (lock_s_q) begin
                    state_d = ST_FILTER;
                end
            end
            ST_FILTER: begin
                if (cnt_q == FILT_LAST) begin
                    state_d = ST_RELEASE;
                    cnt_d   = '0;
                    idx_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ST_RELEASE: begin
                if (cnt_q == DLY_LAST) begin
                    cnt_d = '0;
                    for (int i = 0; i < int'(NUM_STAGES); i++) begin
                        if (IDX_W'(i) == idx_q) begin
                            stage_rst_d[i] = 1'b0;
                        end
                    end
                    if (idx_q == IDX_LAST) begin
                        state_d = ST_RUN;
                    end else begin
                        idx_d = idx_q + IDX_W'(1);
                    end
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ST_RUN: begin
                state_d = ST_RUN;
            end
            default: begin
                state_d = ST_ASSERT;
            end
        endcase

        // Lock loss: Filter restarts the filter, later states abort to Assert.
        // Restoring stage_rst keeps a stage from releasing on the abort edge.
        if (!lock_s_q) begin
            if (state_q == ST_FILTER) begin
                state_d = ST_WAIT_LOCK;
                cnt_d   = '0;
            end else if (state_q == ST_RELEASE || state_q == ST_RUN) begin
                state_d     = ST_ASSERT;
                stage_rst_d = stage_rst_q;
            end
        end

`ifdef H14TX_RSTSEQ_TIMEOUT_EN
        if (timeout_hit_c) begin
            state_d = ST_ASSERT;
            cnt_d   = '0;
        end
`endif

        if (soft_rst_req && state_q != ST_ASSERT) begin
            state_d     = ST_ASSERT;
            stage_rst_d = stage_rst_q;
        end

        ready_d = (state_d == ST_RUN);
        busy_d  = ~ready_d;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_ASSERT;
            cnt_q       <= '0;
            idx_q       <= '0;
            stage_rst_q <= '1;
            ready_q     <= 1'b0;
            busy_q      <= 1'b1;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            idx_q       <= idx_d;
            stage_rst_q <= stage_rst_d;
            ready_q     <= ready_d;
            busy_q      <= busy_d;
        end
    end

    assign stage_rst = stage_rst_q;
    assign ready     = ready_q;
    assign busy      = busy_q;

endmodule

// File: tb/tb_h14tx_reset_sequencer.sv
// Testbench for h14tx_reset_sequencer. Stimulus pushes expected output changes
// (cycle + value) into a scoreboard; a negedge monitor pops one entry whenever the
// DUT outputs change (or when a snapshot entry falls due) and compares.
// Cycle n = value of the posedge counter; inputs driven at the negedge of cycle n
// are first sampled by the edge of cycle n+1.
module tb_h14tx_reset_sequencer;

    localparam int unsigned TO = 200;

    logic       clk = 1'b0;
    logic       rst;
    logic       pll_lock;
    logic       soft_rst_req;
    logic [2:0] stage_rst;
    logic       ready;
    logic       busy;
    logic       lock_timeout;
    logic       pll_rst;

    h14tx_reset_sequencer #(
        .NUM_STAGES    (3),
        .STAGE_DELAY   (16),
        .LOCK_FILTER   (64),
        .TIMEOUT_CYCLES(TO)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .pll_lock    (pll_lock),
        .soft_rst_req(soft_rst_req),
        .stage_rst   (stage_rst),
        .ready       (ready),
        .busy        (busy),
        .lock_timeout(lock_timeout),
        .pll_rst     (pll_rst)
    );

    always #5 clk = ~clk;

    int unsigned cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int unsigned cyc;
        logic [6:0]  val;
        bit          snap;
        string       name;
    } exp_t;

    exp_t sb[$];
    int   n_cmp = 0;
    int   n_err = 0;
    bit   mon_en = 1'b0;
    bit   done = 1'b0;
    bit   done_chk = 1'b0;
    logic [6:0] prev;
    logic [6:0] cur;
    exp_t       e;

    task automatic push(input int unsigned c, input logic [2:0] s, input logic r,
                        input logic t, input logic p, input bit snap, input string nm);
        exp_t x;
        x.cyc  = c;
        x.val  = {s, r, ~r, t, p};
        x.snap = snap;
        x.name = nm;
        sb.push_back(x);
    endtask

    task automatic wait_to(input int unsigned c);
        while (cyc < c) @(negedge clk);
    endtask

    task automatic pulse_soft();
        soft_rst_req = 1'b1;
        @(negedge clk);
        soft_rst_req = 1'b0;
    endtask

    // Monitor: output vector is {stage_rst, ready, busy, lock_timeout, pll_rst}
    always @(negedge clk) begin
        cur = {stage_rst, ready, busy, lock_timeout, pll_rst};
        if (mon_en) begin
            if (sb.size() > 0 && sb[0].snap && sb[0].cyc == cyc) begin
                e = sb.pop_front();
                n_cmp++;
                if (cur !== e.val) begin
                    n_err++;
                    $display("FAIL %s cyc=%0d got=%b exp=%b", e.name, cyc, cur, e.val);
                end
            end else if (cur !== prev) begin
                n_cmp++;
                if (sb.size() == 0) begin
                    n_err++;
                    $display("FAIL unexpected_change cyc=%0d got=%b prev=%b", cyc, cur, prev);
                end else begin
                    e = sb.pop_front();
                    if (cur !== e.val || cyc != e.cyc) begin
                        n_err++;
                        $display("FAIL %s cyc=%0d got=%b exp_cyc=%0d exp=%b",
                                 e.name, cyc, cur, e.cyc, e.val);
                    end
                end
            end
            if (done && !done_chk) begin
                done_chk = 1'b1;
                n_cmp++;
                if (sb.size() != 0) begin
                    n_err++;
                    $display("FAIL missing_events got=%0d pending exp=0 next=%s",
                             sb.size(), sb[0].name);
                end
            end
        end
        prev = cur;
    end

    initial begin
        #200000;
        $display("FAIL watchdog cyc=%0d got=timeout exp=finish", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int unsigned n;
        int unsigned m;
        rst          = 1'b0;
        pll_lock     = 1'b0;
        soft_rst_req = 1'b0;
        #1 rst = 1'b1;
        repeat (3) @(negedge clk);
        mon_en = 1'b1;
        push(cyc + 2, 3'b111, 1'b0, 1'b0, 1'b0, 1'b1, "reset_state");
        wait_to(cyc + 4);
        rst = 1'b0;
        wait_to(cyc + 4);

        // Nominal: sync 2, WaitLock->Filter 1, filter 64, first stage delay 16
        n = cyc;
        pll_lock = 1'b1;
        push(n + 83,  3'b110, 1'b0, 1'b0, 1'b0, 1'b0, "nom_stage0");
        push(n + 99,  3'b100, 1'b0, 1'b0, 1'b0, 1'b0, "nom_stage1");
        push(n + 115, 3'b000, 1'b1, 1'b0, 1'b0, 1'b0, "nom_stage2_ready");
        push(n + 120, 3'b000, 1'b1, 1'b0, 1'b0, 1'b1, "nom_run");
        wait_to(n + 122);

        // Soft reset in Run: ready drops next cycle, stages the cycle after
        n = cyc;
        push(n + 1,   3'b000, 1'b0, 1'b0, 1'b0, 1'b0, "soft_ready_drop");
        push(n + 2,   3'b111, 1'b0, 1'b0, 1'b0, 1'b0, "soft_assert");
        push(n + 83,  3'b110, 1'b0, 1'b0, 1'b0, 1'b0, "soft_stage0");
        push(n + 99,  3'b100, 1'b0, 1'b0, 1'b0, 1'b0, "soft_stage1");
        push(n + 115, 3'b000, 1'b1, 1'b0, 1'b0, 1'b0, "soft_stage2_ready");
        pulse_soft();
        wait_to(n + 122);

        // Async rst mid-Release, between edges
        n = cyc;
        push(n + 1,  3'b000, 1'b0, 1'b0, 1'b0, 1'b0, "arst_pre_ready_drop");
        push(n + 2,  3'b111, 1'b0, 1'b0, 1'b0, 1'b0, "arst_pre_assert");
        push(n + 83, 3'b110, 1'b0, 1'b0, 1'b0, 1'b0, "arst_pre_stage0");
        pulse_soft();
        wait_to(n + 90);
        @(posedge clk);
        #2;
        push(cyc, 3'b111, 1'b0, 1'b0, 1'b0, 1'b0, "async_rst");
        rst = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;

        // Relaunch after rst, then lock loss after stage 0 released
        n = cyc;
        push(n + 83, 3'b110, 1'b0, 1'b0, 1'b0, 1'b0, "relaunch_stage0");
        wait_to(n + 90);
        pll_lock = 1'b0;
        push(n + 94,  3'b111, 1'b0, 1'b0, 1'b0, 1'b0, "lockloss_assert");
        push(n + 100, 3'b111, 1'b0, 1'b0, 1'b0, 1'b1, "lockloss_hold");
        wait_to(n + 100);
        n = cyc;
        pll_lock = 1'b1;
        push(n + 83,  3'b110, 1'b0, 1'b0, 1'b0, 1'b0, "relock_stage0");
        push(n + 99,  3'b100, 1'b0, 1'b0, 1'b0, 1'b0, "relock_stage1");
        push(n + 115, 3'b000, 1'b1, 1'b0, 1'b0, 1'b0, "relock_stage2_ready");
        wait_to(n + 122);

        // Lock glitch at filter cnt=40: Filter re-entered at n+50, full filter again
        n = cyc;
        push(n + 1,   3'b000, 1'b0, 1'b0, 1'b0, 1'b0, "glitch_ready_drop");
        push(n + 2,   3'b111, 1'b0, 1'b0, 1'b0, 1'b0, "glitch_assert");
        push(n + 100, 3'b111, 1'b0, 1'b0, 1'b0, 1'b1, "glitch_hold");
        push(n + 130, 3'b110, 1'b0, 1'b0, 1'b0, 1'b0, "glitch_stage0");
        push(n + 146, 3'b100, 1'b0, 1'b0, 1'b0, 1'b0, "glitch_stage1");
        push(n + 162, 3'b000, 1'b1, 1'b0, 1'b0, 1'b0, "glitch_stage2_ready");
        pulse_soft();
        wait_to(n + 43);
        pll_lock = 1'b0;
        wait_to(n + 47);
        pll_lock = 1'b1;
        wait_to(n + 170);

        // Lock loss in Run and a long lock-less wait
        n = cyc;
        pll_lock = 1'b0;
        push(n + 3, 3'b000, 1'b0, 1'b0, 1'b0, 1'b0, "runloss_ready_drop");
        push(n + 4, 3'b111, 1'b0, 1'b0, 1'b0, 1'b0, "runloss_assert");
`ifdef H14TX_RSTSEQ_TIMEOUT_EN
        push(n + 4 + TO,     3'b111, 1'b0, 1'b1, 1'b1, 1'b0, "timeout_fire");
        push(n + 5 + TO,     3'b111, 1'b0, 1'b1, 1'b0, 1'b0, "timeout_pll_rst_end");
        push(n + 5 + 2 * TO, 3'b111, 1'b0, 1'b1, 1'b1, 1'b0, "timeout_retry");
        push(n + 6 + 2 * TO, 3'b111, 1'b0, 1'b1, 1'b0, 1'b0, "timeout_retry_end");
`endif
        wait_to(n + 2 * TO + 20);
        m = cyc;
`ifdef H14TX_RSTSEQ_TIMEOUT_EN
        push(m + 1, 3'b111, 1'b0, 1'b0, 1'b0, 1'b0, "timeout_cleared");
`else
        push(m + 2, 3'b111, 1'b0, 1'b0, 1'b0, 1'b1, "no_timeout");
`endif
        pulse_soft();
        wait_to(m + 5);

        done = 1'b1;
        repeat (2) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
